regfile_wr_arbiter: RTL and testbench

Shares the register file's single write port between two writeback requesters: ALU writeback on port 0 and memory-load writeback on port 1. It drives the write-enable, write-address and write-data inputs of the register file; the address and enable feed the 5-to-32 write decoder. It owns register-0 write suppression. When configured, it also runs a post-reset clear sequence that zeroes registers 1..31.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/rr_pick2.sv | 18 +
 rtl/regfile_wr_arbiter.sv | 124 ++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package regfile_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS);
  localparam int unsigned DATA_W   = 32;

  // Requester indices into the grant vector; also the encoding of last_grant.
  localparam logic PORT_ALU  = 1'b0;
  localparam logic PORT_LOAD = 1'b1;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-input round-robin picker: one-hot grant, ties go to the port that did not win last.
module rr_pick2
  import regfile_pkg::*;
(
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  // Port 0 wins a tie when port 1 was granted last, and vice versa.
  always_comb begin
    grant_o            = 2'b00;
    grant_o[PORT_ALU]  = valid0_i & (~valid1_i | last_grant_i);
    grant_o[PORT_LOAD] = valid1_i & (~valid0_i | ~last_grant_i);
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: shares one write port between ALU (port 0)
// and load (port 1) writeback, suppresses writes to register 0, and, when
// REGFILE_WR_CLEAR_EN is defined, zeroes registers 1..NUM_REGS-1 after reset.
module regfile_wr_arbiter #(
  parameter int unsigned NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned DATA_W   = regfile_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              ctrl_writeEnable,
  output logic [ADDR_W-1:0] ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg,
  output logic              clear_done
);

  import regfile_pkg::*;

`ifdef REGFILE_WR_CLEAR_EN
  localparam state_e            RESET_STATE = ST_CLEAR;
  localparam logic [ADDR_W-1:0] LAST_REG    = ADDR_W'(NUM_REGS - 1);
  logic [ADDR_W-1:0] cnt_q, cnt_d;
`else
  localparam state_e RESET_STATE = ST_RUN;
`endif

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              serve;
  logic [1:0]        grant;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  rr_pick2 u_pick (
    .valid0_i     (req0_valid),
    .valid1_i     (req1_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  // Ports are served only in RUN and never while reset is asserted.
  assign serve      = (state_q == ST_RUN) && !ctrl_reset;
  assign req0_ready = serve & grant[PORT_ALU];
  assign req1_ready = serve & grant[PORT_LOAD];
  assign clear_done = serve;
  assign xfer       = req0_ready | req1_ready;
  assign sel_addr   = req1_ready ? req1_addr : req0_addr;
  assign sel_data   = req1_ready ? req1_data : req0_data;

  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = waddr_q;
  assign data_writeReg    = wdata_q;

  // Next-state: clear sweep or granted writeback; idle cycles drop we and hold addr/data.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
`ifdef REGFILE_WR_CLEAR_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
`ifdef REGFILE_WR_CLEAR_EN
      ST_CLEAR: begin
        we_d    = 1'b1;
        waddr_d = cnt_q;
        wdata_d = '0;
        cnt_d   = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_REG) begin
          state_d = ST_RUN;
        end
      end
`endif
      ST_RUN: begin
        if (xfer) begin
          last_grant_d = req1_ready ? PORT_LOAD : PORT_ALU;
          we_d         = (sel_addr != '0);
          waddr_d      = sel_addr;
          wdata_d      = sel_data;
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      state_q      <= RESET_STATE;
      last_grant_q <= PORT_LOAD;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
`ifdef REGFILE_WR_CLEAR_EN
      cnt_q        <= ADDR_W'(1);
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
`ifdef REGFILE_WR_CLEAR_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter (honours REGFILE_WR_CLEAR_EN).
module tb_regfile_wr_arbiter;

  logic        clock;
  logic        ctrl_reset;
  logic        req0_valid;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        clear_done;

  regfile_wr_arbiter dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .req0_valid       (req0_valid),
    .req0_addr        (req0_addr),
    .req0_data        (req0_data),
    .req0_ready       (req0_ready),
    .req1_valid       (req1_valid),
    .req1_addr        (req1_addr),
    .req1_data        (req1_data),
    .req1_ready       (req1_ready),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .clear_done       (clear_done)
  );

  typedef struct {
    logic        we;
    logic [4:0]  r;
    logic [31:0] d;
  } exp_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } req_t;

`ifdef REGFILE_WR_CLEAR_EN
  localparam int CLR_CYC = 31;
`else
  localparam int CLR_CYC = 0;
`endif

  exp_t exp_q[$];
  req_t q0[$];
  req_t q1[$];
  int   glog[$];
  int   gcyc[$];
  int   wlog[$];
  int   want[$];

  int total = 0;
  int bad   = 0;
  int cyc;
  int clr_left;
  logic        m_lg;
  logic        mon_en;
  logic        hs_prev;
  logic        hold_known;
  logic [4:0]  last_r;
  logic [31:0] last_d;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_log(input string name, input int got[$], input int exp[$]);
    chk({name, "_len"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      chk(name, 64'(got[i]), 64'(exp[i]));
    end
  endtask

  // Monitor: on each handshake-following cycle or visible write, pop and compare.
  initial begin : monitor
    exp_t e;
    hs_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (!mon_en) begin
        hs_prev = 1'b0;
      end else begin
        if (hs_prev || ctrl_writeEnable) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got we=%0b reg=%0d data=0x%0h, want no write",
                     ctrl_writeEnable, ctrl_writeReg, data_writeReg);
          end else begin
            e = exp_q.pop_front();
            chk("wr_en", 64'(ctrl_writeEnable), 64'(e.we));
            if (e.we) begin
              chk("wr_reg", 64'(ctrl_writeReg), 64'(e.r));
              chk("wr_data", 64'(data_writeReg), 64'(e.d));
              last_r     = e.r;
              last_d     = e.d;
              hold_known = 1'b1;
              if (hs_prev) wlog.push_back(int'(ctrl_writeReg));
            end else begin
              hold_known = 1'b0;
            end
          end
        end else if (hold_known) begin
          chk("hold_reg", 64'(ctrl_writeReg), 64'(last_r));
          chk("hold_data", 64'(data_writeReg), 64'(last_d));
        end
        hs_prev = (req0_valid && req0_ready) || (req1_valid && req1_ready);
      end
    end
  end

  task automatic do_reset(input int n);
    mon_en     = 1'b0;
    ctrl_reset = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h1;
    req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h2;
    repeat (n) @(posedge clock);
    @(negedge clock);
    chk("rst_we", 64'(ctrl_writeEnable), 64'(0));
    chk("rst_reg", 64'(ctrl_writeReg), 64'(0));
    chk("rst_data", 64'(data_writeReg), 64'(0));
    chk("rst_ready0", 64'(req0_ready), 64'(0));
    chk("rst_ready1", 64'(req1_ready), 64'(0));
    chk("rst_clear_done", 64'(clear_done), 64'(0));
    @(posedge clock);
    #1;
    ctrl_reset = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    exp_q.delete();
    q0.delete();
    q1.delete();
    m_lg       = 1'b1;
    clr_left   = CLR_CYC;
    cyc        = 1;
    last_r     = 5'd0;
    last_d     = 32'd0;
    hold_known = 1'b1;
    for (int k = 1; k <= CLR_CYC; k++) exp_q.push_back('{we: 1'b1, r: 5'(k), d: 32'h0});
    mon_en = 1'b1;
  endtask

  // One clock: present queue heads, check readies/clear_done, push expected writes.
  task automatic cycle_step();
    logic e_run, g0, g1;
    req0_valid = (q0.size() > 0);
    req0_addr  = req0_valid ? q0[0].a : 5'd0;
    req0_data  = req0_valid ? q0[0].d : 32'd0;
    req1_valid = (q1.size() > 0);
    req1_addr  = req1_valid ? q1[0].a : 5'd0;
    req1_data  = req1_valid ? q1[0].d : 32'd0;
    e_run = (clr_left == 0);
    g0 = e_run && req0_valid && (!req1_valid || m_lg);
    g1 = e_run && req1_valid && (!req0_valid || !m_lg);
    @(negedge clock);
    chk("ready0", 64'(req0_ready), 64'(g0));
    chk("ready1", 64'(req1_ready), 64'(g1));
    chk("clear_done", 64'(clear_done), 64'(e_run));
    if (req0_valid && req0_ready) begin glog.push_back(0); gcyc.push_back(cyc); end
    if (req1_valid && req1_ready) begin glog.push_back(1); gcyc.push_back(cyc); end
    if (g0) begin
      exp_q.push_back('{we: (req0_addr != 5'd0), r: req0_addr, d: req0_data});
      m_lg = 1'b0;
      void'(q0.pop_front());
    end else if (g1) begin
      exp_q.push_back('{we: (req1_addr != 5'd0), r: req1_addr, d: req1_data});
      m_lg = 1'b1;
      void'(q1.pop_front());
    end
    if (clr_left > 0) clr_left--;
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic run_reqs();
    int budget;
    budget = 100;
    while ((q0.size() > 0 || q1.size() > 0) && budget > 0) begin
      cycle_step();
      budget--;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle_step();
  endtask

  task automatic clear_logs();
    glog.delete();
    gcyc.delete();
    wlog.delete();
  endtask

  initial begin
    mon_en     = 1'b0;
    ctrl_reset = 1'b1;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;

    do_reset(2);
    clear_logs();
`ifdef REGFILE_WR_CLEAR_EN
    // Clear sweep with both ports waiting: first grants land in cycles 32 and 33.
    q0.push_back('{a: 5'd9,  d: 32'hCAFE0009});
    q1.push_back('{a: 5'd10, d: 32'hCAFE000A});
    run_reqs();
    idle(2);
    want = '{0, 1};       chk_log("clear_grants", glog, want);
    want = '{32, 33};     chk_log("clear_grant_cycle", gcyc, want);
    want = '{9, 10};      chk_log("clear_writes", wlog, want);

    // Reset during cycle 10 of the sweep; sequence restarts from register 1.
    do_reset(2);
    idle(9);
    do_reset(1);
    idle(32);
`else
    // No clear: served from the first cycle after reset release.
    q0.push_back('{a: 5'd7, d: 32'hA5A5_0007});
    run_reqs();
    idle(2);
    want = '{0};          chk_log("first_grant", glog, want);
    want = '{1};          chk_log("first_grant_cycle", gcyc, want);
    want = '{7};          chk_log("first_write", wlog, want);
`endif

    // Single ALU write.
    clear_logs();
    q0.push_back('{a: 5'd5, d: 32'hDEADBEEF});
    run_reqs();
    idle(2);
    want = '{0};          chk_log("single_grant", glog, want);
    want = '{5};          chk_log("single_write", wlog, want);

    // Fairness from reset with both ports busy.
    do_reset(2);
    clear_logs();
    q0.push_back('{a: 5'd1, d: 32'h1111_0001});
    q0.push_back('{a: 5'd2, d: 32'h1111_0002});
    q1.push_back('{a: 5'd3, d: 32'h2222_0003});
    q1.push_back('{a: 5'd4, d: 32'h2222_0004});
    run_reqs();
    idle(2);
    want = '{0, 1, 0, 1}; chk_log("fair_grants", glog, want);
    want = '{1, 3, 2, 4}; chk_log("fair_writes", wlog, want);

    // Register 0 write is suppressed but still counts as a grant for fairness.
    clear_logs();
    q1.push_back('{a: 5'd0, d: 32'h12345678});
    run_reqs();
    q0.push_back('{a: 5'd6, d: 32'h3333_0006});
    q1.push_back('{a: 5'd8, d: 32'h4444_0008});
    run_reqs();
    idle(3);
    want = '{1, 0, 1};    chk_log("reg0_grants", glog, want);
    want = '{6, 8};       chk_log("reg0_writes", wlog, want);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
